rack_receiver: RTL and testbench

RACK_RECEIVER -- requirements
Module: rack_receiver

---
 rtl/rack_pkg.sv | 13 +
 rtl/rack_fifo.sv | 57 +++++
 rtl/rack_receiver.sv | 106 ++++++++++
 tb/tb_rack_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rack_pkg.sv
// Shared FSM state type and default sizing for the rack_receiver handshake-to-FIFO bridge.
package rack_pkg;

  localparam int RACK_DATA_W = 8;
  localparam int RACK_DEPTH  = 4;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACK      = 2'd2
  } rack_state_e;

endpackage

// File: rtl/rack_fifo.sv
// Show-ahead FIFO holding captured Rdata words; push is ignored when full, pop when empty.
module rack_fifo
  import rack_pkg::*;
#(
  parameter int DATA_W = RACK_DATA_W,
  parameter int DEPTH  = RACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rack_receiver.sv
// Four-phase Rreq/Rack receiver feeding a show-ahead FIFO.
// Define RREQ_SYNC_EN to pass Rreq through a two-flop synchronizer (asynchronous upstream).
module rack_receiver
  import rack_pkg::*;
#(
  parameter int DATA_W = RACK_DATA_W,
  parameter int DEPTH  = RACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Rreq,
  input  logic [DATA_W-1:0]      Rdata,
  output logic                   Rack,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  rack_state_e r_state;
  logic        r_rack;
  logic        w_rreq_s;
  logic        w_sync_ok;
  logic        w_push;
  logic        w_full;
  logic        w_empty;

`ifdef RREQ_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;
  logic r_sync_vld_p0;
  logic r_sync_vld_p1;

  // The valid shadow keeps WAIT_LOW from trusting the reset zeros before real Rreq samples arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0     <= 1'b0;
      r_sync_p1     <= 1'b0;
      r_sync_vld_p0 <= 1'b0;
      r_sync_vld_p1 <= 1'b0;
    end else begin
      r_sync_p0     <= Rreq;
      r_sync_p1     <= r_sync_p0;
      r_sync_vld_p0 <= 1'b1;
      r_sync_vld_p1 <= r_sync_vld_p0;
    end
  end

  assign w_rreq_s  = r_sync_p1;
  assign w_sync_ok = r_sync_vld_p1;
`else
  assign w_rreq_s  = Rreq;
  assign w_sync_ok = 1'b1;
`endif

  // Fullness is the registered count, so a same-edge pop never frees a slot for this push.
  assign w_push = (r_state == IDLE) && w_rreq_s && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_LOW;
      r_rack  <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (w_sync_ok && !w_rreq_s) r_state <= IDLE;
        end
        IDLE: begin
          if (w_push) begin
            r_state <= ACK;
            r_rack  <= 1'b1;
          end
        end
        ACK: begin
          if (!w_rreq_s) begin
            r_state <= IDLE;
            r_rack  <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_LOW;
          r_rack  <= 1'b0;
        end
      endcase
    end
  end

  assign Rack      = r_rack;
  assign out_valid = !w_empty;

  rack_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (Rdata),
    .i_pop   (out_ready),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

endmodule

// File: tb/tb_rack_receiver.sv
// Self-checking bench for rack_receiver; expected latency follows RREQ_SYNC_EN.
module tb_rack_receiver;

`ifdef RREQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rreq;
  logic [7:0] Rdata;
  logic       Rack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  rack_receiver #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rreq      (Rreq),
    .Rdata     (Rdata),
    .Rack      (Rack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one edge and update the queue model: reset clears, a pop takes the head,
  // an acknowledge rising on that edge means the word on Rdata was accepted.
  task automatic step();
    logic       p_rst, p_rack, p_rdy;
    logic [7:0] p_data;
    p_rst  = rst;
    p_rack = Rack;
    p_rdy  = out_ready;
    p_data = Rdata;
    @(posedge clk);
    #1;
    if (p_rst) q.delete();
    else begin
      if (p_rdy && q.size() > 0) void'(q.pop_front());
      if (p_rack !== 1'b1 && Rack === 1'b1) q.push_back(p_data);
    end
  endtask

  task automatic release_req(input bit rnd_rdy);
    int n = 0;
    Rreq = 1'b0;
    while (Rack !== 1'b0 && n < 200) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (Rack !== 1'b0) begin
      checks++; errors++;
      $display("FAIL rack_release_timeout rack=%b want 0", Rack);
    end
  endtask

  task automatic hs(input logic [7:0] d, input bit rnd_rdy);
    int n = 0;
    Rdata = d;
    Rreq  = 1'b1;
    while (Rack !== 1'b1 && n < 200) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (Rack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rack_ack_timeout data=%h rack=%b want 1", d, Rack);
    end
    release_req(rnd_rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1; Rreq = 1'b0; Rdata = 8'h00; out_ready = 1'b0;
    step(); step();
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL reset_rack got=%b want=0", Rack); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    rst = 1'b0;
    repeat (4) step();
    checks++; if (count !== 3'd0 || Rack !== 1'b0) begin errors++; $display("FAIL reset_idle count=%0d rack=%b want 0/0", count, Rack); end
  endtask

  task automatic test_single();
    Rdata = 8'hA5; Rreq = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      step();
      checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_early_ack edge=%0d got=%b want=0", i, Rack); end
    end
    step();
    checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL single_ack got=%b want=1", Rack); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h want=a5", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d want=1", count); end
    Rreq = 1'b0;
    repeat (LAT) step();
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_release got=%b want=0", Rack); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_fill_stall();
    logic [7:0] exp_rd [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    int n = 0;
    out_ready = 1'b0;
    hs(8'h11, 1'b0); hs(8'h22, 1'b0); hs(8'h33, 1'b0); hs(8'h44, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", count); end
    Rdata = 8'h55; Rreq = 1'b1;
    for (int i = 0; i < 3 * LAT + 3; i++) begin
      step();
      checks++; if (Rack !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL stall_hold rack=%b count=%0d want 0/4", Rack, count); end
    end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL stall_head got=%h want=11", out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (Rack !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL stall_no_bypass rack=%b count=%0d want 0/3", Rack, count); end
    while (Rack !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (Rack !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL stall_resume rack=%b count=%0d want 1/4", Rack, count); end
    release_req(1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_rd[i]) begin errors++; $display("FAIL fill_order idx=%0d got=%h want=%h", i, out_data, exp_rd[i]); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drain got=%0d want=0", count); end
  endtask

  task automatic test_simul();
    logic [7:0] a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    hs(a, 1'b0); hs(b, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_pre got=%0d want=2", count); end
    Rdata = c; Rreq = 1'b1;
    repeat (LAT - 1) step();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL simul_ack got=%b want=1", Rack); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d want=2", count); end
    checks++; if (out_data !== b) begin errors++; $display("FAIL simul_head got=%h want=%h", out_data, b); end
    release_req(1'b0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_data !== c || count !== 3'd1) begin errors++; $display("FAIL simul_tail got=%h/%0d want=%h/1", out_data, count, c); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] d;
    int n = 0;
    d = 8'($urandom);
    Rdata = 8'($urandom); Rreq = 1'b1;
    while (Rack !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL rst_ack_pre got=%b want=1", Rack); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (Rack !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ack_clear rack=%b count=%0d valid=%b want 0/0/0", Rack, count, out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (Rack !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_ack_recapture rack=%b count=%0d want 0/0", Rack, count); end
    end
    Rreq = 1'b0;
    repeat (LAT + 2) step();
    hs(d, 1'b0);
    checks++; if (count !== 3'd1 || out_data !== d) begin errors++; $display("FAIL rst_ack_after got=%0d/%h want=1/%h", count, out_data, d); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    int sent = 0, n = 0, maxc = 0;
    bit high = 0;
    out_ready = 1'b1;
    while (got.size() < 10 && n < 500) begin
      if (!high && Rack === 1'b0 && sent < 10) begin Rdata = 8'(sent); Rreq = 1'b1; high = 1; end
      else if (high && Rack === 1'b1) begin Rreq = 1'b0; high = 0; sent++; end
      if (out_valid === 1'b1) got.push_back(out_data);
      step();
      n++;
      if (int'(count) > maxc) maxc = int'(count);
    end
    Rreq = 1'b0;
    repeat (LAT + 2) step();
    out_ready = 1'b0;
    checks++; if (got.size() !== 10) begin errors++; $display("FAIL wrap_len got=%0d want=10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL wrap_order idx=%0d got=%h want=%h", i, got[i], 8'(i)); end
    end
    checks++; if (maxc > 1) begin errors++; $display("FAIL wrap_maxcount got=%0d want<=1", maxc); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final got=%0d want=0", count); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin out_ready = 1'($urandom_range(0, 1)); step(); end
      hs(8'($urandom), 1'b1);
      checks++; if (count !== q.size()) begin errors++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, count, q.size()); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid it=%0d got=%b want=%b", it, out_valid, q.size() != 0); end
      if (q.size() > 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_data it=%0d got=%h want=%h", it, out_data, q[0]); end
      end
    end
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_simul();
    test_reset_in_ack();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
